// File: rtl/ram_arbiter.sv
// ram_arbiter: grants per-core icache/dcache requests onto one shared RAM port.
// Round-robin across cores, dcache before icache within a core, with a BUSY timeout.
//
// Ports:
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   iREN/iaddr       per-core icache read request and word address
//   dREN/dWEN        per-core dcache read/write request
//   daddr/dstore     per-core dcache word address and write data
//   idone/ddone      one-cycle completion pulse to the granted requester
//   err              one-cycle abort pulse to the core whose request timed out
//   load             registered read data, valid while a done bit is high
//   ramaddr/ramstore RAM address and write data
//   ramREN/ramWEN    RAM read/write strobes (at most one high)
//   ram_ack/ramload  RAM completion and read data (same cycle)
module ram_arbiter #(
    parameter int NCORES  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCORES-1:0]       iREN,
    input  logic [NCORES-1:0][31:0] iaddr,
    input  logic [NCORES-1:0]       dREN,
    input  logic [NCORES-1:0]       dWEN,
    input  logic [NCORES-1:0][31:0] daddr,
    input  logic [NCORES-1:0][31:0] dstore,
    output logic [NCORES-1:0]       idone,
    output logic [NCORES-1:0]       ddone,
    output logic [NCORES-1:0]       err,
    output logic [31:0]             load,
    output logic [31:0]             ramaddr,
    output logic [31:0]             ramstore,
    output logic                    ramREN,
    output logic                    ramWEN,
    input  logic                    ram_ack,
    input  logic [31:0]             ramload
);

    localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     last, last_n;
    logic [CW-1:0]     core, core_n;
    logic              src_d, src_d_n;
    logic [7:0]        cnt, cnt_n;
    logic [31:0]       ramaddr_n, ramstore_n, load_n;
    logic              ramREN_n, ramWEN_n;
    logic [NCORES-1:0] idone_n, ddone_n, err_n;

    logic              found;
    logic [CW-1:0]     pick;

    // Rotating scan: the core after the last one served is looked at first,
    // so every core gets a turn even when others request continuously.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NCORES; k++) begin
            c = int'(last) + k;
            if (c >= NCORES) begin
                c = c - NCORES;
            end
            if (!found && (iREN[c] || dREN[c] || dWEN[c])) begin
                found = 1'b1;
                pick  = CW'(c);
            end
        end
    end

    always_comb begin
        state_n    = state;
        last_n     = last;
        core_n     = core;
        src_d_n    = src_d;
        cnt_n      = cnt;
        ramaddr_n  = ramaddr;
        ramstore_n = ramstore;
        load_n     = load;
        ramREN_n   = ramREN;
        ramWEN_n   = ramWEN;
        idone_n    = '0;
        ddone_n    = '0;
        err_n      = '0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    core_n  = pick;
                    src_d_n = dREN[pick] | dWEN[pick];
                    cnt_n   = '0;
                    state_n = BUSY;
                    if (src_d_n) begin
                        // A simultaneous read and write is treated as a write.
                        ramaddr_n  = daddr[pick];
                        ramstore_n = dstore[pick];
                        ramWEN_n   = dWEN[pick];
                        ramREN_n   = ~dWEN[pick];
                    end else begin
                        ramaddr_n  = iaddr[pick];
                        ramstore_n = '0;
                        ramWEN_n   = 1'b0;
                        ramREN_n   = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack in the final allowed cycle still completes normally.
                if (ram_ack) begin
                    if (ramREN) begin
                        load_n = ramload;
                    end
                    ramREN_n = 1'b0;
                    ramWEN_n = 1'b0;
                    last_n   = core;
                    state_n  = DONE;
                    if (src_d) begin
                        ddone_n[core] = 1'b1;
                    end else begin
                        idone_n[core] = 1'b1;
                    end
                end else if (cnt == CNT_MAX) begin
                    ramREN_n    = 1'b0;
                    ramWEN_n    = 1'b0;
                    last_n      = core;
                    state_n     = DONE;
                    err_n[core] = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            last     <= CW'(NCORES - 1);
            core     <= '0;
            src_d    <= 1'b0;
            cnt      <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            load     <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            idone    <= '0;
            ddone    <= '0;
            err      <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            core     <= core_n;
            src_d    <= src_d_n;
            cnt      <= cnt_n;
            ramaddr  <= ramaddr_n;
            ramstore <= ramstore_n;
            load     <= load_n;
            ramREN   <= ramREN_n;
            ramWEN   <= ramWEN_n;
            idone    <= idone_n;
            ddone    <= ddone_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a transaction-level
// grant-order model, a delay-programmable RAM responder and random batches.
module tb_ram_arbiter;

    localparam int NC = 2;
    localparam int TO = 4;

    logic                CLK = 1'b0;
    logic                nRST = 1'b0;
    logic [NC-1:0]       iREN = '0;
    logic [NC-1:0][31:0] iaddr = '0;
    logic [NC-1:0]       dREN = '0;
    logic [NC-1:0]       dWEN = '0;
    logic [NC-1:0][31:0] daddr = '0;
    logic [NC-1:0][31:0] dstore = '0;
    logic [NC-1:0]       idone, ddone, err;
    logic [31:0]         load, ramaddr, ramstore;
    logic                ramREN, ramWEN;
    logic                ram_ack = 1'b0;
    logic [31:0]         ramload = '0;

    ram_arbiter #(.NCORES(NC), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .idone(idone), .ddone(ddone), .err(err), .load(load),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ram_ack(ram_ack), .ramload(ramload)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          core;
        bit          is_d;
        bit          wr;
        bit          abort;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          busy;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          delay_of[logic [31:0]];
    logic [31:0] data_of[logic [31:0]];
    bit          mon_en = 1'b0;
    int          expect_strobe_cyc = -1;
    int          issue_seq = 0;
    int          applied_seq = 0;
    int          rc = 0;
    int          busy_cnt = 0;
    logic        prev_strobe = 1'b0;

    bit          st_i[NC];
    bit          st_rd[NC];
    bit          st_wr[NC];
    logic [31:0] st_ia[NC];
    logic [31:0] st_da[NC];
    logic [31:0] st_ds[NC];

    int          m_last = NC - 1;
    logic [31:0] m_load = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM responder, monitor/scoreboard and request driver, all on negedge.
    always @(negedge CLK) begin
        logic             strobe;
        logic [3*NC-1:0]  pv;
        int               bit_idx;
        exp_t             e;
        strobe = ramREN | ramWEN;
        pv     = {err, ddone, idone};

        if (strobe) begin
            rc++;
            if (delay_of.exists(ramaddr) && rc == delay_of[ramaddr] + 1) begin
                ram_ack = 1'b1;
                ramload = data_of[ramaddr];
            end else begin
                ram_ack = 1'b0;
                ramload = $urandom;
            end
        end else begin
            rc      = 0;
            ram_ack = 1'($urandom_range(0, 1));
            ramload = $urandom;
        end

        if (mon_en) begin
            if (strobe) begin
                if (!prev_strobe) busy_cnt = 0;
                busy_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", 32'(strobe), 32'd0);
                end else begin
                    e = sbq[0];
                    if (!prev_strobe)
                        chk("grant_cycle", 32'(cyc), 32'(expect_strobe_cyc));
                    chk("ramaddr", ramaddr, e.addr);
                    chk("ramWEN", 32'(ramWEN), 32'(e.wr));
                    chk("ramREN", 32'(ramREN), 32'(!e.wr));
                    if (e.wr) chk("ramstore", ramstore, e.store);
                    if ($urandom_range(0, 3) == 0) begin
                        // Withdraw and disturb the granted request mid-flight.
                        if (e.is_d) begin
                            dREN[e.core] = 1'b0;
                            dWEN[e.core] = 1'b0;
                            daddr[e.core] = daddr[e.core] ^ $urandom;
                            dstore[e.core] = dstore[e.core] ^ $urandom;
                        end else begin
                            iREN[e.core] = 1'b0;
                            iaddr[e.core] = iaddr[e.core] ^ $urandom;
                        end
                    end
                end
            end
            if (pv != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'(pv), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    bit_idx = e.abort ? 2 * NC + e.core :
                              (e.is_d ? NC + e.core : e.core);
                    chk("pulse", 32'(pv), 32'(1) << bit_idx);
                    chk("strobe_off", 32'(strobe), 32'd0);
                    chk("busy_len", 32'(busy_cnt), 32'(e.busy));
                    chk("load", load, e.load);
                    if (e.is_d) begin
                        dREN[e.core] = 1'b0;
                        dWEN[e.core] = 1'b0;
                    end else begin
                        iREN[e.core] = 1'b0;
                    end
                    if (sbq.size() != 0) expect_strobe_cyc = cyc + 2;
                end
            end
        end
        prev_strobe = strobe;

        if (!nRST) begin
            iREN = '0;
            dREN = '0;
            dWEN = '0;
        end else if (issue_seq != applied_seq) begin
            for (int c = 0; c < NC; c++) begin
                iREN[c]   = st_i[c];
                dREN[c]   = st_rd[c];
                dWEN[c]   = st_wr[c];
                iaddr[c]  = st_ia[c];
                daddr[c]  = st_da[c];
                dstore[c] = st_ds[c];
            end
            applied_seq = issue_seq;
            expect_strobe_cyc = cyc + 1;
        end
    end

    task automatic clear_stage();
        for (int c = 0; c < NC; c++) begin
            st_i[c] = 1'b0;
            st_rd[c] = 1'b0;
            st_wr[c] = 1'b0;
            st_ia[c] = $urandom;
            st_da[c] = $urandom;
            st_ds[c] = $urandom;
        end
    endtask

    task automatic add_i(int c, logic [31:0] a, int dly, logic [31:0] dat);
        st_i[c] = 1'b1;
        st_ia[c] = a;
        delay_of[a] = dly;
        data_of[a] = dat;
    endtask

    task automatic add_d(int c, bit rd, bit wr, logic [31:0] a,
                         logic [31:0] s, int dly, logic [31:0] dat);
        st_rd[c] = rd;
        st_wr[c] = wr;
        st_da[c] = a;
        st_ds[c] = s;
        delay_of[a] = dly;
        data_of[a] = dat;
    endtask

    // Reference: serve every staged request in rotating-priority order,
    // predicting outcome from the RAM delay attached to its address.
    task automatic run_batch();
        bit   pi[NC];
        bit   pd[NC];
        int   g, c, d, w;
        exp_t e;
        for (int k = 0; k < NC; k++) begin
            pi[k] = st_i[k];
            pd[k] = st_rd[k] | st_wr[k];
        end
        forever begin
            g = -1;
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (g < 0 && (pi[c] || pd[c])) g = c;
            end
            if (g < 0) break;
            e.core = g;
            e.is_d = pd[g];
            if (pd[g]) begin
                e.wr = st_wr[g];
                e.addr = st_da[g];
                e.store = st_ds[g];
                pd[g] = 1'b0;
            end else begin
                e.wr = 1'b0;
                e.addr = st_ia[g];
                e.store = '0;
                pi[g] = 1'b0;
            end
            d = delay_of[e.addr];
            e.abort = (d + 1 > TO);
            e.busy = e.abort ? TO : d + 1;
            if (!e.abort && !e.wr) m_load = data_of[e.addr];
            e.load = m_load;
            m_last = g;
            sbq.push_back(e);
        end
        issue_seq++;
        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge CLK);
            w++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        sbq.delete();
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] base;
        #1;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_pulses", 32'({err, ddone, idone}), 32'd0);
        chk("rst_load", load, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK);

        clear_stage();
        add_d(1, 1'b1, 1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        run_batch();

        clear_stage();
        add_d(0, 1'b1, 1'b1, 32'h80, 32'h12345678, 0, 32'hAAAA5555);
        run_batch();

        clear_stage();
        add_i(0, 32'h90, 0, 32'h11111111);
        add_d(0, 1'b1, 1'b0, 32'hA0, 32'h0, 1, 32'h22222222);
        run_batch();

        clear_stage();
        add_i(0, 32'h300, 0, 32'h33330000);
        add_i(1, 32'h310, 2, 32'h33331111);
        add_d(0, 1'b1, 1'b0, 32'h320, 32'h0, 0, 32'h33332222);
        add_d(1, 1'b1, 1'b0, 32'h330, 32'h0, 1, 32'h33333333);
        run_batch();

        clear_stage();
        add_d(1, 1'b1, 1'b0, 32'h400, 32'h0, 99, 32'h44444444);
        run_batch();

        clear_stage();
        add_d(0, 1'b1, 1'b0, 32'h410, 32'h0, TO - 1, 32'h5A5A5A5A);
        run_batch();

        // Asynchronous reset in the middle of a read.
        mon_en = 1'b0;
        clear_stage();
        add_d(0, 1'b1, 1'b0, 32'h200, 32'h0, 99, 32'h0);
        issue_seq++;
        w = 0;
        while (!ramREN && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk("midbusy_ramREN", 32'(ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("async_ramREN", 32'(ramREN), 32'd0);
        chk("async_ramWEN", 32'(ramWEN), 32'd0);
        chk("async_load", load, 32'd0);
        chk("async_pulses", 32'({err, ddone, idone}), 32'd0);
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b1;
        m_last = NC - 1;
        m_load = '0;
        sbq.delete();
        @(negedge CLK);
        mon_en = 1'b1;

        clear_stage();
        add_i(0, 32'h100, 0, 32'h0BADF00D);
        run_batch();

        for (int b = 0; b < 60; b++) begin
            clear_stage();
            base = 32'h1000_0000 + 32'(b * 64);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1)
                    add_i(c, base + 32'(c * 16), $urandom_range(0, 5), $urandom);
                case ($urandom_range(0, 3))
                    1: add_d(c, 1'b1, 1'b0, base + 32'(c * 16 + 4), $urandom,
                             $urandom_range(0, 5), $urandom);
                    2: add_d(c, 1'b0, 1'b1, base + 32'(c * 16 + 4), $urandom,
                             $urandom_range(0, 5), $urandom);
                    3: add_d(c, 1'b1, 1'b1, base + 32'(c * 16 + 4), $urandom,
                             $urandom_range(0, 5), $urandom);
                    default: ;
                endcase
            end
            if (!st_i[0] && !st_i[1] && !st_rd[0] && !st_rd[1] &&
                !st_wr[0] && !st_wr[1])
                add_i(1, base + 32'h30, 0, $urandom);
            run_batch();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
